parity_stream: RTL and testbench
================================

# parity_stream

Streaming parity generator/checker for the parity family, successor to the single-word combinational generator. Accepts `DATA_W`-bit words on a valid/ready stream, computes one parity bit per `GROUP_W`-bit group in even or odd mode, and either appends the parity (generate beats) or compares it against supplied parity (check beats). Registered, full-throughput, back-pressure safe; keeps a saturating error count for status readout.

## Interface
- `DATA_W`, 8, data word width; must be a multiple of `GROUP_W`.
- `GROUP_W`, 8, bits covered by each parity bit; `NG = DATA_W/GROUP_W`.
- `ERR_CNT_W`, 16, width of the error counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `odd_mode`  in  1  0 = even parity, 1 = odd parity; sampled per accepted beat.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_data`  in  DATA_W  input word.
- `s_par`  in  NG  received parity, used only on check beats.
- `s_check`  in  1  1 = check beat, 0 = generate beat.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_W  word, passed unchanged.
- `m_par`  out  NG  computed parity, bit g covers `s_data[g*GROUP_W +: GROUP_W]`.
- `m_err`  out  NG  per-group mismatch; all zero on generate beats.
- `clr_count`  in  1  synchronous clear of `err_count`.
- `err_count`  out  ERR_CNT_W  saturating count of erroneous output beats.

## Operation
- Even mode: `par[g]` = XOR of group g. Odd mode: `par[g]` = inverted XOR.
- Check beat: `m_err[g] = computed par[g] XOR s_par[g]`. Generate beat: `m_err = 0`.
- `odd_mode`, `s_check`, `s_data` and `s_par` are captured together on acceptance (`s_valid && s_ready`). A mode change between beats affects only later beats.
- Storage is a two-entry skid: a main output register plus one skid register.
  - Accept while the main register is empty, or is draining this cycle: the beat goes to the main register.
  - Accept while the main register is held (`m_valid && !m_ready`): the beat goes to the skid register.
  - When the main register drains and the skid is full, the skid moves to the main register.
- `s_ready` = skid register empty. It is registered and has no combinational path from `m_ready`.
- Output beats never drop, duplicate or reorder. `m_*` stay stable while `m_valid && !m_ready`.
- Error counter:
  - Increments by 1 on an output handshake with `|m_err`.
  - Saturates at all-ones.
  - `clr_count` has priority over the increment in the same cycle; the result is 0.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented with `m_valid=1` after edge N.
- Throughput is 1 beat/cycle with `m_ready` held high.
- After one stall cycle, `s_ready` drops in the cycle after the skid fills. It recovers in the cycle after the main register drains.
- Reset values: `m_valid=0`, `m_data=0`, `m_par=0`, `m_err=0`, `err_count=0`, `s_ready=1`.
- Reset asserted mid-stream discards both entries immediately (asynchronous). No beat is emitted after release until a new acceptance.
- `s_valid` with `s_ready=0` is ignored, and the input is not captured.

## Structure
- Shared package `parity_pkg`:
  - constants `PAR_EVEN=1'b0`, `PAR_ODD=1'b1`;
  - function `group_parity(data, odd)` returning the NG-bit vector, reused by the future parity checker/ECC blocks.
- Sub-module `parity_skid`: a generic two-entry valid/ready skid buffer parametrised by payload width. The top packs `{data, par, err}` into its payload.
- The top holds the parity compute, the payload packing and the error counter.

## Test plan
- `DATA_W=8`, even, generate, `s_data=8'h03` -> `m_par=0`, `m_err=0`. Same word with odd -> `m_par=1`.
- `DATA_W=16`, `GROUP_W=8`, check beat `s_data=16'h0701`, even, `s_par=2'b11` -> `m_par=2'b11`, `m_err=0`. Then `s_par=2'b01` -> `m_err=2'b10`, `err_count` 0 -> 1 after handshake.
- Back-pressure stream:
  - Drive beats 1..20 continuously while toggling `m_ready` pseudo-randomly.
  - Required: output sequence 1..20 in order, each once.
  - Required: `s_ready` low only while the skid is full; outputs stable during stalls.
- `ERR_CNT_W=3`: 9 erroneous beats -> `err_count` sticks at 7. `clr_count` asserted on the same cycle as an erroneous handshake -> 0.
- Mid-stream reset:
  - Two beats buffered under `m_ready=0`, then `rst` pulsed.
  - Required: `m_valid=0`, `s_ready=1`, `err_count=0`; no stale beat emitted after release.
- Mode change between back-to-back beats, word `8'hFF`, even then odd -> `m_par` 0 then 1.

Source files
------------

// File: rtl/parity_stream_pkg.sv
// Shared definitions for the parity family: parity mode constants, beat kinds
// and the grouped parity helper reused by the checker and ECC blocks.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Widest word the helper accepts; narrower words are zero-extended by the caller.
  localparam int PAR_MAX_W  = 64;
  localparam int PAR_MAX_NG = 64;

  typedef enum logic {
    BEAT_GEN   = 1'b0,
    BEAT_CHECK = 1'b1
  } beat_kind_e;

  // Bit g of the result covers data[g*group_w +: group_w]; callers keep the low NG bits.
  function automatic logic [PAR_MAX_NG-1:0] group_parity(
    input logic [PAR_MAX_W-1:0] data,
    input logic                 odd,
    input int                   group_w = 8
  );
    logic [PAR_MAX_NG-1:0] par;
    par = {PAR_MAX_NG{1'b0}};
    if (group_w > 0) begin
      for (int b = 0; b < PAR_MAX_W; b++) begin
        par[b / group_w] = par[b / group_w] ^ data[b];
      end
    end else begin
      par = {PAR_MAX_NG{1'b0}};
    end
    return par ^ {PAR_MAX_NG{odd}};
  endfunction

endpackage

// File: rtl/parity_stream_if.sv
// Stream bundle for parity_stream: input beat, output beat and error status.
interface parity_stream_if #(
  parameter int DATA_W    = 8,
  parameter int GROUP_W   = 8,
  parameter int ERR_CNT_W = 16
);
  localparam int NG = DATA_W / GROUP_W;

  logic                 odd_mode;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;
  logic [NG-1:0]        s_par;
  logic                 s_check;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_W-1:0]    m_data;
  logic [NG-1:0]        m_par;
  logic [NG-1:0]        m_err;
  logic                 clr_count;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  odd_mode, s_valid, s_data, s_par, s_check, m_ready, clr_count,
    output s_ready, m_valid, m_data, m_par, m_err, err_count
  );

  modport master (
    output odd_mode, s_valid, s_data, s_par, s_check, m_ready, clr_count,
    input  s_ready, m_valid, m_data, m_par, m_err, err_count
  );

endinterface

// File: rtl/parity_skid.sv
// Generic two-entry valid/ready skid buffer: a main output register plus one
// skid register; in_ready depends only on local state, never on out_ready.
module parity_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r;
  logic [W-1:0] main_r;
  logic         skid_valid_r;
  logic [W-1:0] skid_r;

  assign in_ready  = ~skid_valid_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_r;

  // Main/skid occupancy: refill main from skid first so order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_r       <= '0;
      skid_valid_r <= 1'b0;
      skid_r       <= '0;
    end else if (!main_valid_r || out_ready) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_valid) begin
        main_r       <= in_data;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (in_valid && !skid_valid_r) begin
      skid_r       <= in_data;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

endmodule

// File: rtl/parity_stream.sv
// Streaming grouped parity generator/checker with a skid-buffered output and a
// saturating error counter.
module parity_stream
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GROUP_W   = 8,
  parameter int ERR_CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  parity_stream_if.slave  bus
);

  localparam int NG    = DATA_W / GROUP_W;
  localparam int PAY_W = DATA_W + 2 * NG;

  logic [NG-1:0]        par_s;
  logic [NG-1:0]        err_s;
  beat_kind_e           kind_s;
  logic [PAY_W-1:0]     pay_in_s;
  logic [PAY_W-1:0]     pay_out_s;
  logic                 m_valid_s;
  logic [NG-1:0]        m_err_s;
  logic [ERR_CNT_W-1:0] err_count_r;

  // Parity and mismatch are computed on the incoming beat, so mode and check
  // flag are frozen into the payload at the moment of acceptance.
  always_comb begin
    par_s  = NG'(group_parity(PAR_MAX_W'(bus.s_data), bus.odd_mode, GROUP_W));
    kind_s = beat_kind_e'(bus.s_check);
    err_s  = '0;
    case (kind_s)
      BEAT_CHECK: err_s = par_s ^ bus.s_par;
      BEAT_GEN:   err_s = '0;
      default:    err_s = '0;
    endcase
  end

  assign pay_in_s = {bus.s_data, par_s, err_s};

  parity_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.s_valid),
    .in_ready  (bus.s_ready),
    .in_data   (pay_in_s),
    .out_valid (m_valid_s),
    .out_ready (bus.m_ready),
    .out_data  (pay_out_s)
  );

  assign m_err_s     = pay_out_s[NG-1:0];
  assign bus.m_valid = m_valid_s;
  assign bus.m_data  = pay_out_s[PAY_W-1 -: DATA_W];
  assign bus.m_par   = pay_out_s[2*NG-1 -: NG];
  assign bus.m_err   = m_err_s;
  assign bus.err_count = err_count_r;

  // Error counter: clear wins over a same-cycle erroneous handshake; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= '0;
    end else if (bus.clr_count) begin
      err_count_r <= '0;
    end else if (m_valid_s && bus.m_ready && (|m_err_s) && (err_count_r != {ERR_CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + ERR_CNT_W'(1);
    end else begin
      err_count_r <= err_count_r;
    end
  end

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench for parity_stream: vector table plus back-pressure, saturation,
// clear-priority, mode-change and mid-stream reset sequences.
module tb_parity_stream;
  import parity_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_stream_if #(.DATA_W(8),  .GROUP_W(8), .ERR_CNT_W(3))  b8 ();
  parity_stream_if #(.DATA_W(16), .GROUP_W(8), .ERR_CNT_W(16)) b16 ();

  parity_stream #(.DATA_W(8),  .GROUP_W(8), .ERR_CNT_W(3))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  parity_stream #(.DATA_W(16), .GROUP_W(8), .ERR_CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic       check;
    logic       spar;
    logic       exp_par;
    logic       exp_err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic drive8(input logic [7:0] d, input logic odd, input logic check, input logic spar);
    b8.s_valid  = 1'b1;
    b8.s_data   = d;
    b8.odd_mode = odd;
    b8.s_check  = check;
    b8.s_par    = spar;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   next_in;
    int   exp_out;
    int   occ;
    logic in_hs;
    logic out_hs;
    logic prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp8;

    vecs[0] = '{8'h03, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, PAR_ODD,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, PAR_ODD,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h01, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h01, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, PAR_ODD,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h80, PAR_ODD,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h00, PAR_EVEN, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'h3C, PAR_EVEN, 1'b1, 1'b1, 1'b0, 1'b1};

    b8.s_valid = 1'b0;  b8.s_data = 8'h00;   b8.s_par = 1'b0;  b8.s_check = 1'b0;
    b8.odd_mode = 1'b0; b8.m_ready = 1'b0;   b8.clr_count = 1'b0;
    b16.s_valid = 1'b0; b16.s_data = 16'h0000; b16.s_par = 2'b00; b16.s_check = 1'b0;
    b16.odd_mode = 1'b0; b16.m_ready = 1'b0; b16.clr_count = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_m_valid", b8.m_valid, 1'b0);
    chk("rst_m_data", b8.m_data, 8'h00);
    chk("rst_m_par", b8.m_par, 1'b0);
    chk("rst_m_err", b8.m_err, 1'b0);
    chk("rst_err_count", b8.err_count, 3'd0);
    chk("rst_s_ready", b8.s_ready, 1'b1);
    chk("rst16_s_ready", b16.s_ready, 1'b1);

    // Back-to-back table beats; each is checked one cycle after it is driven.
    b8.m_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("tbl_m_valid", b8.m_valid, 1'b1);
        chk("tbl_m_data", b8.m_data, vecs[i-1].data);
        chk("tbl_m_par", b8.m_par, vecs[i-1].exp_par);
        chk("tbl_m_err", b8.m_err, vecs[i-1].exp_err);
      end
      if (i < NV) drive8(vecs[i].data, vecs[i].odd, vecs[i].check, vecs[i].spar);
      else b8.s_valid = 1'b0;
    end
    @(negedge clk);
    chk("tbl_err_count", b8.err_count, 3'd3);
    chk("tbl_drained", b8.m_valid, 1'b0);

    // 16-bit, two groups: 0x0701 -> parity 2'b11.
    b16.m_ready = 1'b1;
    b16.s_valid = 1'b1; b16.s_data = 16'h0701; b16.odd_mode = PAR_EVEN;
    b16.s_check = 1'b1; b16.s_par = 2'b11;
    @(negedge clk);
    chk("w16_m_valid", b16.m_valid, 1'b1);
    chk("w16_m_par", b16.m_par, 2'b11);
    chk("w16_m_err_ok", b16.m_err, 2'b00);
    b16.s_par = 2'b01;
    @(negedge clk);
    chk("w16_m_par2", b16.m_par, 2'b11);
    chk("w16_m_err_bad", b16.m_err, 2'b10);
    chk("w16_cnt_before", b16.err_count, 16'd0);
    b16.s_valid = 1'b0;
    @(negedge clk);
    chk("w16_cnt_after", b16.err_count, 16'd1);
    chk("w16_drained", b16.m_valid, 1'b0);

    // Saturation of a 3-bit counter, then clear against an erroneous handshake.
    b8.clr_count = 1'b1;
    @(negedge clk);
    b8.clr_count = 1'b0;
    chk("clr_only", b8.err_count, 3'd0);
    for (int k = 0; k < 9; k++) begin
      drive8(8'h01, PAR_EVEN, 1'b1, 1'b0);
      @(negedge clk);
    end
    b8.s_valid = 1'b0;
    @(negedge clk);
    chk("sat_count", b8.err_count, 3'd7);
    drive8(8'h01, PAR_EVEN, 1'b1, 1'b0);
    @(negedge clk);
    b8.s_valid = 1'b0;
    chk("clr_pri_err_vis", b8.m_err, 1'b1);
    b8.clr_count = 1'b1;
    @(negedge clk);
    b8.clr_count = 1'b0;
    chk("clr_priority", b8.err_count, 3'd0);

    // Back-pressure stream 1..20 against a bench occupancy model.
    next_in = 1; exp_out = 1; occ = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int cyc = 0; cyc < 400 && exp_out <= 20; cyc++) begin
      @(negedge clk);
      chk("bp_s_ready", b8.s_ready, occ < 2);
      chk("bp_m_valid", b8.m_valid, occ > 0);
      if (prev_stall) chk("bp_stable", b8.m_data, prev_data);
      b8.m_ready = 1'($urandom_range(0, 1));
      if (next_in <= 20) drive8(8'(next_in), PAR_EVEN, 1'b0, 1'b0);
      else b8.s_valid = 1'b0;
      out_hs = b8.m_valid && b8.m_ready;
      in_hs  = b8.s_valid && b8.s_ready;
      if (out_hs) begin
        exp8 = 8'(exp_out);
        chk("bp_m_data", b8.m_data, exp8);
        chk("bp_m_par", b8.m_par, ^exp8);
        exp_out++;
      end
      if (in_hs) next_in++;
      occ = occ + int'(in_hs) - int'(out_hs);
      prev_stall = b8.m_valid && !b8.m_ready;
      prev_data  = b8.m_data;
    end
    @(negedge clk);
    b8.s_valid = 1'b0;
    chk("bp_all_out", 32'(exp_out), 32'd21);
    chk("bp_no_extra", b8.m_valid, 1'b0);

    // Mid-stream asynchronous reset with both entries full.
    b8.m_ready = 1'b1;
    drive8(8'h01, PAR_EVEN, 1'b1, 1'b0);
    @(negedge clk);
    b8.s_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", b8.err_count, 3'd1);
    b8.m_ready = 1'b0;
    drive8(8'h11, PAR_EVEN, 1'b0, 1'b0);
    @(negedge clk);
    drive8(8'h22, PAR_EVEN, 1'b0, 1'b0);
    @(negedge clk);
    b8.s_valid = 1'b0;
    chk("pre_rst_s_ready", b8.s_ready, 1'b0);
    chk("pre_rst_m_data", b8.m_data, 8'h11);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", b8.m_valid, 1'b0);
    chk("mid_rst_s_ready", b8.s_ready, 1'b1);
    chk("mid_rst_count", b8.err_count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    b8.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_beat", b8.m_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
